// File: rtl/udp_vlg_port_mux_if.sv
// ---------------------------------------------------------------------------
// udp_vlg_port_mux_if
// Bundle of every stream/bus signal around udp_vlg_port_mux.
//   ch_port            local UDP port per channel (0 = channel disabled)
//   ch_tx_*            per-channel TX byte streams and frame metadata
//   udp_tx_*           merged TX stream toward the UDP stack
//   udp_rx_*           received UDP stream from the stack
//   ch_rx_*            demultiplexed RX strobes plus shared data/metadata
//   rx_drop_cnt        frames received with no matching channel
// Modports:
//   slave  - the mux itself
//   master - the surrounding logic (channels + UDP stack)
// ---------------------------------------------------------------------------
interface udp_vlg_port_mux_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0][15:0] ch_port;

    logic [N_CH-1:0]       ch_tx_val;
    logic [N_CH-1:0]       ch_tx_sof;
    logic [N_CH-1:0]       ch_tx_eof;
    logic [N_CH-1:0][7:0]  ch_tx_dat;
    logic [N_CH-1:0][31:0] ch_tx_dst_ip;
    logic [N_CH-1:0][15:0] ch_tx_dst_port;
    logic [N_CH-1:0][15:0] ch_tx_len;
    logic [N_CH-1:0]       ch_tx_rdy;

    logic                  udp_tx_val;
    logic                  udp_tx_sof;
    logic                  udp_tx_eof;
    logic [7:0]            udp_tx_dat;
    logic [15:0]           udp_tx_src_port;
    logic [15:0]           udp_tx_dst_port;
    logic [31:0]           udp_tx_dst_ip;
    logic [15:0]           udp_tx_len;
    logic                  udp_tx_rdy;

    logic                  udp_rx_val;
    logic                  udp_rx_sof;
    logic                  udp_rx_eof;
    logic [7:0]            udp_rx_dat;
    logic [15:0]           udp_rx_dst_port;
    logic [15:0]           udp_rx_src_port;
    logic [31:0]           udp_rx_src_ip;

    logic [N_CH-1:0]       ch_rx_val;
    logic [N_CH-1:0]       ch_rx_sof;
    logic [N_CH-1:0]       ch_rx_eof;
    logic [7:0]            ch_rx_dat;
    logic [15:0]           ch_rx_src_port;
    logic [31:0]           ch_rx_src_ip;

    logic [15:0]           rx_drop_cnt;

    modport slave (
        input  ch_port,
        input  ch_tx_val, ch_tx_sof, ch_tx_eof, ch_tx_dat,
        input  ch_tx_dst_ip, ch_tx_dst_port, ch_tx_len,
        output ch_tx_rdy,
        output udp_tx_val, udp_tx_sof, udp_tx_eof, udp_tx_dat,
        output udp_tx_src_port, udp_tx_dst_port, udp_tx_dst_ip, udp_tx_len,
        input  udp_tx_rdy,
        input  udp_rx_val, udp_rx_sof, udp_rx_eof, udp_rx_dat,
        input  udp_rx_dst_port, udp_rx_src_port, udp_rx_src_ip,
        output ch_rx_val, ch_rx_sof, ch_rx_eof, ch_rx_dat,
        output ch_rx_src_port, ch_rx_src_ip,
        output rx_drop_cnt
    );

    modport master (
        output ch_port,
        output ch_tx_val, ch_tx_sof, ch_tx_eof, ch_tx_dat,
        output ch_tx_dst_ip, ch_tx_dst_port, ch_tx_len,
        input  ch_tx_rdy,
        input  udp_tx_val, udp_tx_sof, udp_tx_eof, udp_tx_dat,
        input  udp_tx_src_port, udp_tx_dst_port, udp_tx_dst_ip, udp_tx_len,
        output udp_tx_rdy,
        output udp_rx_val, udp_rx_sof, udp_rx_eof, udp_rx_dat,
        output udp_rx_dst_port, udp_rx_src_port, udp_rx_src_ip,
        input  ch_rx_val, ch_rx_sof, ch_rx_eof, ch_rx_dat,
        input  ch_rx_src_port, ch_rx_src_ip,
        input  rx_drop_cnt
    );
endinterface

// File: rtl/udp_vlg_port_mux.sv
// ---------------------------------------------------------------------------
// udp_vlg_port_mux
// Shares one UDP stack between N_CH local channels.
//   TX: round-robin frame arbiter; the granted channel's byte stream is passed
//       through combinationally, its port/metadata held for the whole frame.
//   RX: frames are steered by destination port to the lowest-index channel
//       whose ch_port matches; unmatched frames are discarded and counted.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active low
//   bus  - udp_vlg_port_mux_if.slave (all stream, metadata and status signals)
//
// TX FSM
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | no frame in flight, all ch_tx_rdy low, arbitrating requests
//   ST_SEND   | granted channel's bytes forwarded until its eof transfers
// ---------------------------------------------------------------------------
module udp_vlg_port_mux #(
    parameter int N_CH       = 4,
    parameter int VERBOSE    = 1,
    parameter     DUT_STRING = ""
) (
    input  logic               clk,
    input  logic               rst,
    udp_vlg_port_mux_if.slave  bus
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    if (N_CH < 2 || N_CH > 16) begin : g_n_ch_range
        $error("udp_vlg_port_mux: N_CH must be within 2..16");
    end

    // Frame logging lives outside the synthesized mux; a bound monitor
    // attaches here when VERBOSE is set.
    if (VERBOSE > 0 && $bits(DUT_STRING) >= 0) begin : g_log_hook
    end

    // ------------------------------------------------------------------ TX
    logic [0:0]      tx_st;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [N_CH-1:0] tx_req;
    logic            rr_found;
    logic [GW-1:0]   rr_pick;
    logic [GW-1:0]   rr_cand;
    logic [15:0]     tx_src_port;
    logic [15:0]     tx_dst_port;
    logic [31:0]     tx_dst_ip;
    logic [15:0]     tx_len;

    always_comb begin
        tx_req = '0;
        for (int i = 0; i < N_CH; i++) begin
            tx_req[i] = bus.ch_tx_val[i] & bus.ch_tx_sof[i] & (bus.ch_port[i] != 16'd0);
        end
    end

    // Search begins one past the previous winner so every channel gets a turn.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            rr_cand = GW'((int'(last_grant) + k) % N_CH);
            if (!rr_found && tx_req[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st       <= ST_IDLE;
            grant       <= '0;
            last_grant  <= GW'(N_CH - 1);
            tx_src_port <= '0;
            tx_dst_port <= '0;
            tx_dst_ip   <= '0;
            tx_len      <= '0;
        end else begin
            case (tx_st)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant       <= rr_pick;
                        tx_src_port <= bus.ch_port[rr_pick];
                        tx_dst_port <= bus.ch_tx_dst_port[rr_pick];
                        tx_dst_ip   <= bus.ch_tx_dst_ip[rr_pick];
                        tx_len      <= bus.ch_tx_len[rr_pick];
                        tx_st       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // ch_port is not consulted here, so a channel disabled
                    // mid-frame still completes the frame it started.
                    if (bus.ch_tx_val[grant] && bus.udp_tx_rdy && bus.ch_tx_eof[grant]) begin
                        last_grant <= grant;
                        tx_st      <= ST_IDLE;
                    end
                end
                default: tx_st <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ch_tx_rdy  = '0;
        bus.udp_tx_val = 1'b0;
        bus.udp_tx_sof = 1'b0;
        bus.udp_tx_eof = 1'b0;
        bus.udp_tx_dat = 8'd0;
        if (tx_st == ST_SEND) begin
            bus.udp_tx_val       = bus.ch_tx_val[grant];
            bus.udp_tx_sof       = bus.ch_tx_sof[grant];
            bus.udp_tx_eof       = bus.ch_tx_eof[grant];
            bus.udp_tx_dat       = bus.ch_tx_dat[grant];
            bus.ch_tx_rdy[grant] = bus.udp_tx_rdy;
        end
    end

    assign bus.udp_tx_src_port = tx_src_port;
    assign bus.udp_tx_dst_port = tx_dst_port;
    assign bus.udp_tx_dst_ip   = tx_dst_ip;
    assign bus.udp_tx_len      = tx_len;

    // ------------------------------------------------------------------ RX
    logic            rx_open;     // a frame is in progress
    logic            rx_keep;     // open frame has a target (else discarding)
    logic [GW-1:0]   rx_tgt;
    logic            rx_hit;
    logic [GW-1:0]   rx_hit_idx;
    logic [N_CH-1:0] rx_val_q;
    logic [N_CH-1:0] rx_sof_q;
    logic [N_CH-1:0] rx_eof_q;
    logic [7:0]      rx_dat_q;
    logic [15:0]     rx_src_port_q;
    logic [31:0]     rx_src_ip_q;
    logic [15:0]     rx_drop_q;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        rx_hit     = 1'b0;
        rx_hit_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.ch_port[i] != 16'd0 && bus.ch_port[i] == bus.udp_rx_dst_port) begin
                rx_hit     = 1'b1;
                rx_hit_idx = GW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_open       <= 1'b0;
            rx_keep       <= 1'b0;
            rx_tgt        <= '0;
            rx_val_q      <= '0;
            rx_sof_q      <= '0;
            rx_eof_q      <= '0;
            rx_dat_q      <= '0;
            rx_src_port_q <= '0;
            rx_src_ip_q   <= '0;
            rx_drop_q     <= '0;
        end else begin
            rx_val_q <= '0;
            rx_sof_q <= '0;
            rx_eof_q <= '0;
            if (bus.udp_rx_val) begin
                if (bus.udp_rx_sof) begin
                    // A sof always restarts framing; any open frame is simply
                    // abandoned without an eof toward its channel.
                    rx_open <= ~bus.udp_rx_eof;
                    rx_keep <= rx_hit;
                    rx_tgt  <= rx_hit_idx;
                    if (rx_hit) begin
                        rx_val_q[rx_hit_idx] <= 1'b1;
                        rx_sof_q[rx_hit_idx] <= 1'b1;
                        rx_eof_q[rx_hit_idx] <= bus.udp_rx_eof;
                        rx_dat_q             <= bus.udp_rx_dat;
                        rx_src_port_q        <= bus.udp_rx_src_port;
                        rx_src_ip_q          <= bus.udp_rx_src_ip;
                    end else if (rx_drop_q != 16'hFFFF) begin
                        rx_drop_q <= rx_drop_q + 16'd1;
                    end
                end else if (rx_open) begin
                    if (rx_keep) begin
                        rx_val_q[rx_tgt] <= 1'b1;
                        rx_eof_q[rx_tgt] <= bus.udp_rx_eof;
                        rx_dat_q         <= bus.udp_rx_dat;
                    end
                    if (bus.udp_rx_eof) begin
                        rx_open <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.ch_rx_val      = rx_val_q;
    assign bus.ch_rx_sof      = rx_sof_q;
    assign bus.ch_rx_eof      = rx_eof_q;
    assign bus.ch_rx_dat      = rx_dat_q;
    assign bus.ch_rx_src_port = rx_src_port_q;
    assign bus.ch_rx_src_ip   = rx_src_ip_q;
    assign bus.rx_drop_cnt    = rx_drop_q;

endmodule
